// File: rtl/params_pkg.sv
// Shared RV32I decode types, widths and opcode/format helpers for the decode stage.
package params_pkg;

    localparam int DATA_WIDTH         = 32;
    localparam int ADDR_WIDTH         = 32;
    localparam int REGISTER_WIDTH     = 5;
    localparam int DEFAULT_NUM_BYPASS = 2;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        OP_IMM = 7'b0010011,
        AUIPC  = 7'b0010111,
        STORE  = 7'b0100011,
        OP     = 7'b0110011,
        LUI    = 7'b0110111,
        BRANCH = 7'b1100011,
        JALR   = 7'b1100111,
        JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        opcode_e    opcode;
    } instruction_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(opcode_e op);
        case (op)
            LOAD, OP_IMM, JALR: return IMM_I;
            STORE:              return IMM_S;
            BRANCH:             return IMM_B;
            JAL:                return IMM_J;
            LUI, AUIPC:         return IMM_U;
            default:            return IMM_NONE;
        endcase
    endfunction

    function automatic logic uses_rs1(opcode_e op);
        case (op)
            LOAD, STORE, BRANCH, OP, OP_IMM, JALR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(opcode_e op);
        case (op)
            STORE, BRANCH, OP: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, x0 hardwired clear.
module decode_scoreboard #(
    parameter int REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      set_en_i,
    input  logic [REGISTER_WIDTH-1:0] set_reg_i,
    input  logic                      clr_en_i,
    input  logic [REGISTER_WIDTH-1:0] clr_reg_i,
    input  logic [REGISTER_WIDTH-1:0] q1_reg_i,
    output logic                      q1_pending_o,
    input  logic [REGISTER_WIDTH-1:0] q2_reg_i,
    output logic                      q2_pending_o
);

    localparam int NUM_REGS = 2 ** REGISTER_WIDTH;

    logic [NUM_REGS-1:0] pending_vec;

    genvar gi;
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        if (gi == 0) begin : g_zero
            assign pending_vec[gi] = 1'b0;
        end else begin : g_live
            logic pending_reg;
            // Set is checked first so a same-cycle set and clear leaves the bit pending.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pending_reg <= 1'b0;
                end else if (set_en_i && set_reg_i == REGISTER_WIDTH'(gi)) begin
                    pending_reg <= 1'b1;
                end else if (clr_en_i && clr_reg_i == REGISTER_WIDTH'(gi)) begin
                    pending_reg <= 1'b0;
                end
            end
            assign pending_vec[gi] = pending_reg;
        end
    end

    assign q1_pending_o = pending_vec[q1_reg_i];
    assign q2_pending_o = pending_vec[q2_reg_i];

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode stage: immediate decode, priority operand bypass, load-use stall and ALU slot.
// Optional DECODE_PERF_CNT_EN adds saturating stall/flush event counters.
module decode_hazard_stage
    import params_pkg::*;
#(
    parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = params_pkg::ADDR_WIDTH,
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int NUM_BYPASS     = params_pkg::DEFAULT_NUM_BYPASS
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic                                 flush_i,
    input  logic [ADDR_WIDTH-1:0]                pc_i,
    input  instruction_t                         instruction_i,
    output logic [REGISTER_WIDTH-1:0]            rs1_o,
    output logic [REGISTER_WIDTH-1:0]            rs2_o,
    input  logic [DATA_WIDTH-1:0]                rs1_data_i,
    input  logic [DATA_WIDTH-1:0]                rs2_data_i,
    input  logic [NUM_BYPASS-1:0]                byp_valid_i,
    input  logic [NUM_BYPASS*REGISTER_WIDTH-1:0] byp_reg_i,
    input  logic [NUM_BYPASS*DATA_WIDTH-1:0]     byp_data_i,
    input  logic                                 wb_reg_wr_en_i,
    input  logic [REGISTER_WIDTH-1:0]            wb_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]                wb_data_to_reg_i,
    input  logic                                 alu_ready_i,
    output logic                                 alu_valid_o,
    output logic [ADDR_WIDTH-1:0]                alu_pc_o,
    output logic [DATA_WIDTH-1:0]                alu_rs1_data_o,
    output logic [DATA_WIDTH-1:0]                alu_rs2_data_o,
    output logic [DATA_WIDTH-1:0]                offset_sign_extend_o,
`ifdef DECODE_PERF_CNT_EN
    output logic [31:0]                          perf_stall_cnt_o,
    output logic [31:0]                          perf_flush_cnt_o,
`endif
    output instruction_t                         instruction_o
);

    localparam int RW = REGISTER_WIDTH;

    opcode_e           opcode;
    logic [31:0]       instr_bits;
    logic [RW-1:0]     rs1_idx;
    logic [RW-1:0]     rs2_idx;
    logic [RW-1:0]     rd_idx;

    assign instr_bits = instruction_i;
    assign opcode     = instruction_i.opcode;
    assign rs1_idx    = RW'(instruction_i.rs1);
    assign rs2_idx    = RW'(instruction_i.rs2);
    assign rd_idx     = RW'(instruction_i.rd);
    assign rs1_o      = rs1_idx;
    assign rs2_o      = rs2_idx;

    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] imm_next;

    always_comb begin
        imm32 = '0;
        case (imm_fmt_of(opcode))
            IMM_I:   imm32 = {{20{instr_bits[31]}}, instr_bits[31:20]};
            IMM_S:   imm32 = {{20{instr_bits[31]}}, instr_bits[31:25], instr_bits[11:7]};
            IMM_B:   imm32 = {{19{instr_bits[31]}}, instr_bits[31], instr_bits[7],
                              instr_bits[30:25], instr_bits[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr_bits[31]}}, instr_bits[31], instr_bits[19:12],
                              instr_bits[20], instr_bits[30:21], 1'b0};
            IMM_U:   imm32 = {instr_bits[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_next = DATA_WIDTH'($signed(imm32));

    // Per-channel match vectors; channel 0 is the youngest result.
    logic [NUM_BYPASS-1:0] hit1;
    logic [NUM_BYPASS-1:0] hit2;
    logic [DATA_WIDTH-1:0] ch_data [NUM_BYPASS];

    genvar gi;
    for (gi = 0; gi < NUM_BYPASS; gi++) begin : g_byp
        logic [RW-1:0] ch_reg;
        assign ch_reg      = byp_reg_i[gi*RW +: RW];
        assign ch_data[gi] = byp_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign hit1[gi]    = byp_valid_i[gi] && (ch_reg == rs1_idx);
        assign hit2[gi]    = byp_valid_i[gi] && (ch_reg == rs2_idx);
    end

    logic [DATA_WIDTH-1:0] fwd1;
    logic [DATA_WIDTH-1:0] fwd2;

    // Walk oldest to youngest so the lowest matching index is the last write.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
            if (hit1[i]) fwd1 = ch_data[i];
            if (hit2[i]) fwd2 = ch_data[i];
        end
    end

    logic                  wb_hit1;
    logic                  wb_hit2;
    logic [DATA_WIDTH-1:0] op1_next;
    logic [DATA_WIDTH-1:0] op2_next;

    assign wb_hit1 = wb_reg_wr_en_i && (wb_wr_reg_i == rs1_idx);
    assign wb_hit2 = wb_reg_wr_en_i && (wb_wr_reg_i == rs2_idx);

    always_comb begin
        op1_next = rs1_data_i;
        op2_next = rs2_data_i;
        if (rs1_idx == '0)   op1_next = '0;
        else if (|hit1)      op1_next = fwd1;
        else if (wb_hit1)    op1_next = wb_data_to_reg_i;
        if (rs2_idx == '0)   op2_next = '0;
        else if (|hit2)      op2_next = fwd2;
        else if (wb_hit2)    op2_next = wb_data_to_reg_i;
    end

    logic pend1;
    logic pend2;
    logic hazard;
    logic slot_free;
    logic load_en;
    logic sb_set_en;
    logic alu_valid_reg;

    assign hazard = (uses_rs1(opcode) && pend1 && !(|hit1) && !wb_hit1)
                 || (uses_rs2(opcode) && pend2 && !(|hit2) && !wb_hit2);

    assign slot_free = !alu_valid_reg || alu_ready_i;
    assign ready_o   = flush_i || (slot_free && !hazard);
    assign load_en   = valid_i && ready_o && !flush_i && slot_free;
    assign sb_set_en = load_en && (opcode == LOAD) && (rd_idx != '0);

    decode_scoreboard #(
        .REGISTER_WIDTH (REGISTER_WIDTH)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_en_i     (sb_set_en),
        .set_reg_i    (rd_idx),
        .clr_en_i     (wb_reg_wr_en_i),
        .clr_reg_i    (wb_wr_reg_i),
        .q1_reg_i     (rs1_idx),
        .q1_pending_o (pend1),
        .q2_reg_i     (rs2_idx),
        .q2_pending_o (pend2)
    );

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] rs1_data_reg;
    logic [DATA_WIDTH-1:0] rs2_data_reg;
    logic [DATA_WIDTH-1:0] imm_reg;
    instruction_t          instr_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_valid_reg <= 1'b0;
            pc_reg        <= '0;
            rs1_data_reg  <= '0;
            rs2_data_reg  <= '0;
            imm_reg       <= '0;
            instr_reg     <= '0;
        end else if (load_en) begin
            alu_valid_reg <= 1'b1;
            pc_reg        <= pc_i;
            rs1_data_reg  <= op1_next;
            rs2_data_reg  <= op2_next;
            imm_reg       <= imm_next;
            instr_reg     <= instruction_i;
        end else if (alu_ready_i) begin
            alu_valid_reg <= 1'b0;
        end
    end

    assign alu_valid_o          = alu_valid_reg;
    assign alu_pc_o             = pc_reg;
    assign alu_rs1_data_o       = rs1_data_reg;
    assign alu_rs2_data_o       = rs2_data_reg;
    assign offset_sign_extend_o = imm_reg;
    assign instruction_o        = instr_reg;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (valid_i && hazard && !flush_i && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (valid_i && flush_i && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_reg;
    assign perf_flush_cnt_o = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Directed and randomized bench for decode_hazard_stage against a transaction-level model.
module tb_decode_hazard_stage;

    localparam int NB = 2;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, flush_i, alu_ready_i, ready_o, alu_valid_o;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, ins_w, ins_o_w;
    logic [4:0]  rs1_o, rs2_o;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        b_valid [NB];
    logic [4:0]  b_reg   [NB];
    logic [31:0] b_data  [NB];
    logic [NB-1:0]    byp_valid_i;
    logic [NB*5-1:0]  byp_reg_i;
    logic [NB*32-1:0] byp_data_i;
    logic [31:0] alu_pc_o, alu_rs1_data_o, alu_rs2_data_o, offset_sign_extend_o;
    params_pkg::instruction_t instruction_i, instruction_o;

    assign instruction_i = params_pkg::instruction_t'(ins_w);
    assign ins_o_w       = instruction_o;
    assign byp_valid_i   = {b_valid[1], b_valid[0]};
    assign byp_reg_i     = {b_reg[1], b_reg[0]};
    assign byp_data_i    = {b_data[1], b_data[0]};

    always #5 clk_i = ~clk_i;

    decode_hazard_stage #(.NUM_BYPASS(NB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .pc_i(pc_i), .instruction_i(instruction_i),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .byp_valid_i(byp_valid_i), .byp_reg_i(byp_reg_i), .byp_data_i(byp_data_i),
        .wb_reg_wr_en_i(wb_en), .wb_wr_reg_i(wb_reg), .wb_data_to_reg_i(wb_data),
        .alu_ready_i(alu_ready_i), .alu_valid_o(alu_valid_o), .alu_pc_o(alu_pc_o),
        .alu_rs1_data_o(alu_rs1_data_o), .alu_rs2_data_o(alu_rs2_data_o),
        .offset_sign_extend_o(offset_sign_extend_o), .instruction_o(instruction_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: the ALU slot as a record plus a set of pending registers.
    logic        m_valid, m_was_reset;
    logic [31:0] m_pc, m_a, m_b, m_imm, m_ins;
    bit          pending [32];
    logic        exp_ready, exp_accept, last_ready;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [6:0] op, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
        return {7'b0, r2, r1, 3'b0, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [4:0] r1, logic [11:0] imm);
        return {imm, r1, 3'b0, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(logic [4:0] r1, logic [4:0] r2, logic [12:0] imm);
        return {imm[12], imm[10:5], r2, r1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
    endfunction
    function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic bit reads_rs1(logic [6:0] op);
        return op inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OPIMM, OPC_JALR};
    endfunction
    function automatic bit reads_rs2(logic [6:0] op);
        return op inside {OPC_STORE, OPC_BRANCH, OPC_OP};
    endfunction

    // Immediate value computed arithmetically from the instruction fields.
    function automatic logic [31:0] ref_imm(logic [31:0] w);
        int s;
        s = $signed(w);
        case (w[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: return 32'(s >>> 20);
            OPC_STORE:  return 32'((s >>> 25) * 32 + int'(w[11:7]));
            OPC_BRANCH: return 32'((w[31] ? -4096 : 0) + int'(w[7]) * 2048
                                   + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            OPC_JAL:    return 32'((w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096
                                   + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            OPC_LUI, OPC_AUIPC: return {w[31:12], 12'h000};
            default:    return 32'h0;
        endcase
    endfunction

    function automatic bit forwarded(logic [4:0] idx);
        for (int c = 0; c < NB; c++)
            if (b_valid[c] && b_reg[c] == idx) return 1'b1;
        return wb_en && wb_reg == idx;
    endfunction

    function automatic logic [31:0] ref_operand(logic [4:0] idx, logic [31:0] rf);
        if (idx == 5'd0) return 32'h0;
        for (int c = 0; c < NB; c++)
            if (b_valid[c] && b_reg[c] == idx) return b_data[c];
        if (wb_en && wb_reg == idx) return wb_data;
        return rf;
    endfunction

    task automatic model_eval();
        bit haz, free;
        haz = (reads_rs1(ins_w[6:0]) && pending[ins_w[19:15]] && !forwarded(ins_w[19:15]))
           || (reads_rs2(ins_w[6:0]) && pending[ins_w[24:20]] && !forwarded(ins_w[24:20]));
        free = !m_valid || alu_ready_i;
        exp_ready  = flush_i || (free && !haz);
        exp_accept = valid_i && exp_ready && !flush_i && free;
    endtask

    task automatic model_commit();
        if (rst_i) begin
            m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_ins = 0;
            for (int r = 0; r < 32; r++) pending[r] = 0;
            m_was_reset = 1;
        end else begin
            m_was_reset = 0;
            if (wb_en) pending[wb_reg] = 0;
            if (exp_accept) begin
                m_valid = 1;
                m_pc    = pc_i;
                m_a     = ref_operand(ins_w[19:15], rs1_data_i);
                m_b     = ref_operand(ins_w[24:20], rs2_data_i);
                m_imm   = ref_imm(ins_w);
                m_ins   = ins_w;
                if (ins_w[6:0] == OPC_LOAD && ins_w[11:7] != 5'd0) pending[ins_w[11:7]] = 1;
            end else if (alu_ready_i) begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: check decode-side outputs before the edge, slot outputs after it.
    task automatic cycle();
        #1;
        model_eval();
        last_ready = ready_o;
        chk("ready_o", ready_o, exp_ready);
        chk("rs1_o", rs1_o, ins_w[19:15]);
        chk("rs2_o", rs2_o, ins_w[24:20]);
        @(posedge clk_i);
        model_commit();
        #1;
        chk("alu_valid_o", alu_valid_o, m_valid);
        if (m_valid || m_was_reset) begin
            chk("alu_pc_o", alu_pc_o, m_pc);
            chk("alu_rs1_data_o", alu_rs1_data_o, m_a);
            chk("alu_rs2_data_o", alu_rs2_data_o, m_b);
            chk("offset_sign_extend_o", offset_sign_extend_o, m_imm);
            chk("instruction_o", ins_o_w, m_ins);
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        rst_i = 0; valid_i = 0; flush_i = 0; alu_ready_i = 1;
        wb_en = 0; wb_reg = 0; wb_data = 0;
        for (int c = 0; c < NB; c++) begin
            b_valid[c] = 0; b_reg[c] = 0; b_data[c] = 0;
        end
        pc_i = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom;
        ins_w = enc_r(OPC_OP, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [9];
        ops = '{OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
        m_valid = 0; m_was_reset = 0; exp_ready = 0; exp_accept = 0; last_ready = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_imm = 0; m_ins = 0;

        idle(); rst_i = 1; valid_i = 1;
        @(negedge clk_i);
        cycle();
        chk("reset_valid", alu_valid_o, 1'b0);
        chk("reset_pc", alu_pc_o, 32'h0);

        idle(); valid_i = 1; ins_w = enc_u(OPC_LUI, 5'd1, 20'h12345);
        cycle(); chk("imm_lui", offset_sign_extend_o, 32'h12345000);
        idle(); valid_i = 1; ins_w = enc_b(5'd1, 5'd2, 13'h1FFC);
        cycle(); chk("imm_beq_m4", offset_sign_extend_o, 32'hFFFFFFFC);
        idle(); valid_i = 1; ins_w = enc_i(OPC_JALR, 5'd1, 5'd2, 12'h7FF);
        cycle(); chk("imm_jalr", offset_sign_extend_o, 32'h000007FF);
        idle(); valid_i = 1; rs1_data_i = 32'hDEAD; ins_w = enc_i(OPC_OPIMM, 5'd1, 5'd0, 12'd5);
        cycle(); chk("x0_operand", alu_rs1_data_o, 32'h0);

        idle(); valid_i = 1; ins_w = enc_r(OPC_OP, 5'd1, 5'd5, 5'd5);
        b_valid[0] = 1; b_reg[0] = 5'd5; b_data[0] = 32'hAAAA;
        b_valid[1] = 1; b_reg[1] = 5'd5; b_data[1] = 32'hBBBB;
        wb_en = 1; wb_reg = 5'd5; wb_data = 32'hCCCC;
        cycle(); chk("byp0_rs1", alu_rs1_data_o, 32'hAAAA); chk("byp0_rs2", alu_rs2_data_o, 32'hAAAA);
        b_valid[0] = 0;
        cycle(); chk("byp1_rs1", alu_rs1_data_o, 32'hBBBB); chk("byp1_rs2", alu_rs2_data_o, 32'hBBBB);
        b_valid[1] = 0;
        cycle(); chk("wb_rs1", alu_rs1_data_o, 32'hCCCC); chk("wb_rs2", alu_rs2_data_o, 32'hCCCC);

        idle(); valid_i = 1; ins_w = enc_i(OPC_LOAD, 5'd3, 5'd2, 12'd0);
        cycle(); chk("lw_accept", alu_valid_o, 1'b1);
        idle(); valid_i = 1; ins_w = enc_r(OPC_OP, 5'd4, 5'd3, 5'd2);
        cycle(); chk("loaduse_stall0", last_ready, 1'b0);
        cycle(); chk("loaduse_stall1", last_ready, 1'b0); chk("stall_drained", alu_valid_o, 1'b0);
        wb_en = 1; wb_reg = 5'd3; wb_data = 32'h1234;
        cycle(); chk("loaduse_release", last_ready, 1'b1); chk("loaduse_data", alu_rs1_data_o, 32'h1234);

        idle(); valid_i = 1; pc_i = 32'h100; ins_w = enc_i(OPC_OPIMM, 5'd6, 5'd0, 12'd7);
        cycle();
        idle(); alu_ready_i = 0; valid_i = 1; pc_i = 32'h104; ins_w = enc_i(OPC_OPIMM, 5'd7, 5'd0, 12'd9);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready", last_ready, 1'b0);
            chk("bp_pc_hold", alu_pc_o, 32'h100);
            chk("bp_imm_hold", offset_sign_extend_o, 32'd7);
        end
        alu_ready_i = 1;
        cycle(); chk("bp_release_ready", last_ready, 1'b1);
        chk("bp_next_pc", alu_pc_o, 32'h104); chk("bp_next_imm", offset_sign_extend_o, 32'd9);

        idle(); valid_i = 1; ins_w = enc_i(OPC_LOAD, 5'd3, 5'd0, 12'd0);
        cycle();
        idle(); valid_i = 1; flush_i = 1; ins_w = enc_r(OPC_OP, 5'd4, 5'd3, 5'd0);
        cycle(); chk("flush_ready", last_ready, 1'b1); chk("flush_no_load", alu_valid_o, 1'b0);
        flush_i = 0;
        cycle(); chk("flush_x3_pending", last_ready, 1'b0);
        wb_en = 1; wb_reg = 5'd3; wb_data = 32'h55;
        cycle();

        idle(); valid_i = 1; ins_w = enc_i(OPC_LOAD, 5'd7, 5'd0, 12'd0);
        cycle();
        idle(); valid_i = 1; ins_w = enc_r(OPC_OP, 5'd8, 5'd7, 5'd7);
        cycle(); chk("pre_reset_stall", last_ready, 1'b0);
        rst_i = 1;
        cycle(); chk("midstall_reset_valid", alu_valid_o, 1'b0);
        rst_i = 0;
        cycle(); chk("reset_sb_empty", last_ready, 1'b1);

        for (int n = 0; n < 500; n++) begin
            logic [31:0] w;
            idle();
            rst_i       = ($urandom_range(0, 59) == 0);
            valid_i     = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 9) == 0);
            alu_ready_i = ($urandom_range(0, 3) != 0);
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 8)];
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            ins_w = w;
            for (int c = 0; c < NB; c++) begin
                b_valid[c] = ($urandom_range(0, 3) == 0);
                b_reg[c]   = 5'($urandom_range(0, 7));
                b_data[c]  = $urandom;
            end
            wb_en   = ($urandom_range(0, 2) == 0);
            wb_reg  = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_hazard_stage.md
Name: decode_hazard_stage

Overview:
- Parametrised next-generation decode stage. Sits between fetch and the ALU stage.
- Decodes the immediate for all RV32I formats and reads rs1/rs2 through a priority bypass network with NUM_BYPASS in-flight channels plus writeback.
- Tracks long-latency (LOAD) destinations in a scoreboard and stalls fetch on unresolved use.
- Drives the ALU stage through a registered valid/ready pipeline slot.

Parameters:
- DATA_WIDTH, params_pkg::DATA_WIDTH (32): operand/immediate width.
- ADDR_WIDTH, params_pkg::ADDR_WIDTH (32): PC width.
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5): register index width; scoreboard has 2**REGISTER_WIDTH entries.
- NUM_BYPASS, 2: forwarding channels; index 0 is youngest (highest priority).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- valid_i  in  1  fetch presents an instruction.
- ready_o  out  1  decode consumes the instruction this cycle.
- flush_i  in  1  branch taken / jump: discard the current decode instruction.
- pc_i  in  ADDR_WIDTH  instruction PC.
- instruction_i  in  instruction_t  fetched instruction.
- rs1_o, rs2_o  out  REGISTER_WIDTH each  register-file read indices (combinational from instruction_i).
- rs1_data_i, rs2_data_i  in  DATA_WIDTH each  register-file read data.
- byp_valid_i  in  NUM_BYPASS  channel carries a valid result.
- byp_reg_i  in  NUM_BYPASS x REGISTER_WIDTH  channel destination register.
- byp_data_i  in  NUM_BYPASS x DATA_WIDTH  channel data.
- wb_reg_wr_en_i  in  1  writeback write enable.
- wb_wr_reg_i  in  REGISTER_WIDTH  writeback register.
- wb_data_to_reg_i  in  DATA_WIDTH  writeback data.
- alu_ready_i  in  1  ALU stage accepts.
- alu_valid_o  out  1  output slot holds a valid instruction.
- alu_pc_o  out  ADDR_WIDTH  registered PC.
- alu_rs1_data_o, alu_rs2_data_o  out  DATA_WIDTH each  resolved operands.
- offset_sign_extend_o  out  DATA_WIDTH  decoded immediate.
- instruction_o  out  instruction_t  registered instruction.
- Clocking/reset (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst_i=1 at posedge): alu_valid_o=0; all data outputs, instruction_o and the scoreboard cleared to 0. rst_i overrides every other input, including a stall in progress.
- Immediate, combinational from instruction_i:
  - LOAD, OP_IMM, JALR: I-type.
  - STORE: S-type.
  - BRANCH: B-type (bit0=0).
  - JAL: J-type.
  - LUI, AUIPC: {imm[31:12], 12'b0}.
  - Otherwise 0.
- Source usage:
  - rs1 used by LOAD, STORE, BRANCH, OP, OP_IMM, JALR.
  - rs2 used by STORE, BRANCH, OP.
  - Unused sources never cause a hazard.
- Operand resolution, per source:
  - Source index 0: operand is 0.
  - Otherwise, the lowest-index byp channel with byp_valid_i and matching reg wins.
  - If no channel matches, writeback data if wb_reg_wr_en_i and matching.
  - Otherwise the register-file data.
- Scoreboard:
  - Pending bit per register.
  - Set when a LOAD with rd!=0 moves into the output slot.
  - Cleared when wb_reg_wr_en_i writes that register.
  - Same register set and cleared in the same cycle: set wins.
  - Bit 0 is never set.
- Hazard: a used source is pending and is resolved neither by a bypass channel nor by writeback in that cycle.
- Slot handshake:
  - slot_free = !alu_valid_o || alu_ready_i.
  - ready_o = flush_i || (slot_free && !hazard).
- Load (accept) condition: valid_i && ready_o && !flush_i && slot_free. On load, the slot captures pc, operands, immediate and instruction, and sets alu_valid_o=1. Latency is 1 cycle from acceptance to alu_valid_o.
- No load and alu_ready_i=1: alu_valid_o goes to 0.
- No load and alu_ready_i=0: slot contents held unchanged.
- Flush:
  - flush_i discards the decode instruction; no scoreboard set.
  - The output slot is unaffected.
  - flush_i with a hazard: flush wins (ready_o=1).
- Stall: while a hazard persists, ready_o=0 and no bubble is loaded. alu_valid_o drops once the slot drains.

Optional Feature:
- DECODE_PERF_CNT_EN defined:
  - Adds ports perf_stall_cnt_o (32) and perf_flush_cnt_o (32).
  - perf_stall_cnt_o increments each cycle that valid_i && hazard && !flush_i.
  - perf_flush_cnt_o increments each cycle that valid_i && flush_i.
  - Both saturate at all-ones and reset to 0.
- Undefined: no ports, no counter logic.

Decomposition:
- params_pkg holds:
  - opcode enum, including OP_IMM, JALR, LUI, AUIPC.
  - instruction_t.
  - imm_fmt_e (I/S/B/J/U/NONE).
  - DEFAULT_NUM_BYPASS.
- One sub-module, decode_scoreboard: pending vector, set/clear ports, two query ports returning the pending bits.

Test Plan:
- Reset mid-stall: hazard pending, assert rst_i → next cycle alu_valid_o=0, scoreboard empty, ready_o=1 for a non-hazard instruction.
- Bypass priority: byp0 and byp1 both target x5 (0xAAAA, 0xBBBB), wb x5=0xCCCC, instruction add x1,x5,x5 → alu_rs1_data_o=alu_rs2_data_o=0xAAAA; with byp0 invalid → 0xBBBB; with both invalid → 0xCCCC.
- Load-use: lw x3 accepted, then add x4,x3,x2 with no bypass/wb → ready_o=0 until wb writes x3=0x1234. In that cycle ready_o=1 and alu_rs1_data_o=0x1234 next cycle.
- Backpressure: alu_ready_i=0 for 3 cycles with alu_valid_o=1 → outputs stable, ready_o=0. On release, the next instruction loads the following cycle.
- Flush during hazard: pending x3, add x4,x3,x0 with flush_i=1 → ready_o=1, alu_valid_o not set by it, x3 still pending.
- Immediates: lui x1,0x12345 → 0x12345000. beq with imm −4 → 0xFFFFFFFC. jalr imm 0x7FF → 0x000007FF. x0 source with rs1_data_i=0xDEAD → operand 0.
